seq_ctrl: RTL

- Multi-cycle fetch/decode/execute sequencer for the TinyCPU core.
- Sits between instruction memory, the 8-bit program counter, the ALU and data memory.
- Decides each cycle whether the PC holds, steps by one or loads a target.
- Holds the instruction register and a small return-address stack (RAS) for CALL/RET.

---
 rtl/seq_pkg.sv | 27 ++
 rtl/ras_stack.sv | 55 +++++
 rtl/seq_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the TinyCPU fetch/decode/execute sequencer.
package seq_pkg;

    // Opcodes, taken from IR[15:12]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JZ   = 4'h5;
    localparam logic [3:0] OP_JNZ  = 4'h6;
    localparam logic [3:0] OP_CALL = 4'h7;
    localparam logic [3:0] OP_RET  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Sequencer states
    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXEC    = 3'd2;
    localparam logic [2:0] S_MEMWAIT = 3'd3;
    localparam logic [2:0] S_HALT    = 3'd4;

    // Sticky fault register bit positions
    localparam int FAULT_RAS = 0;  // return-address stack overflow/underflow
    localparam int FAULT_ILL = 1;  // illegal opcode

endpackage

// File: rtl/ras_stack.sv
// Return-address stack. The pointer runs 0..RAS_DEPTH so that "full" and
// "empty" are both directly visible without a separate count flag.
module ras_stack
    import seq_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] top
);

    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]                  ptr_q, ptr_d;
    logic [RAS_DEPTH-1:0][ADDR_W-1:0]  mem_q, mem_d;
    logic [IDX_W-1:0]                  wr_idx, top_idx;

    assign full    = (ptr_q == PTR_W'(RAS_DEPTH));
    assign empty   = (ptr_q == '0);
    assign wr_idx  = IDX_W'(ptr_q);
    assign top_idx = IDX_W'(ptr_q - PTR_W'(1));
    assign top     = mem_q[top_idx];

    // Next-state: push writes at the pointer, pop just moves it back
    always_comb begin
        ptr_d = ptr_q;
        mem_d = mem_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_data;
            ptr_d         = ptr_q + PTR_W'(1);
        end else if (pop && !empty) begin
            ptr_d = ptr_q - PTR_W'(1);
        end
    end

    // Stack registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            mem_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for TinyCPU. Owns the IR,
// the return-address stack and the sticky fault bits; drives PC, ALU and
// data-memory strobes as combinational functions of state, IR and inputs.
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int INSTR_W   = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               imem_req,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               zero_flag,
    output logic               pc_step,
    output logic               jump_en,
    output logic [ADDR_W-1:0]  jump_addr,
    output logic               alu_en,
    output logic               reg_we,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ready,
    output logic [INSTR_W-1:0] ir_out,
    output logic               halted,
    output logic [1:0]         fault
);

    logic [2:0]         state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [1:0]         fault_q, fault_d;

    logic [3:0]         opcode;
    logic [ADDR_W-1:0]  ir_target;
    logic [ADDR_W-1:0]  ret_addr;

    logic               ras_push, ras_pop, ras_full, ras_empty;
    logic [ADDR_W-1:0]  ras_top;

    // Raw strobes before the reset gate
    logic               imem_req_r, pc_step_r, jump_en_r, alu_en_r, reg_we_r;
    logic               dmem_req_r, dmem_we_r, halted_r;
    logic [ADDR_W-1:0]  jump_addr_r;

    assign opcode    = ir_q[INSTR_W-1:INSTR_W-4];
    assign ir_target = ir_q[ADDR_W-1:0];
    assign ret_addr  = pc_in + ADDR_W'(1);   // wraps 0xFF -> 0x00

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (ret_addr),
        .full      (ras_full),
        .empty     (ras_empty),
        .top       (ras_top)
    );

    // Sequencer next-state, IR/fault update and strobe decode
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        fault_d     = fault_q;
        imem_req_r  = 1'b0;
        pc_step_r   = 1'b0;
        jump_en_r   = 1'b0;
        jump_addr_r = '0;
        alu_en_r    = 1'b0;
        reg_we_r    = 1'b0;
        dmem_req_r  = 1'b0;
        dmem_we_r   = 1'b0;
        halted_r    = 1'b0;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req_r = 1'b1;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: state_d = S_EXEC;

            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_NOP: pc_step_r = 1'b1;
                    OP_ALU: begin
                        alu_en_r  = 1'b1;
                        reg_we_r  = 1'b1;
                        pc_step_r = 1'b1;
                    end
                    OP_LD, OP_ST: state_d = S_MEMWAIT;
                    OP_JMP: begin
                        jump_en_r   = 1'b1;
                        jump_addr_r = ir_target;
                    end
                    OP_JZ, OP_JNZ: begin
                        if (zero_flag == (opcode == OP_JZ)) begin
                            jump_en_r   = 1'b1;
                            jump_addr_r = ir_target;
                        end else begin
                            pc_step_r = 1'b1;
                        end
                    end
                    OP_CALL: begin
                        if (ras_full) begin
                            fault_d[FAULT_RAS] = 1'b1;
                            state_d            = S_HALT;
                        end else begin
                            ras_push    = 1'b1;
                            jump_en_r   = 1'b1;
                            jump_addr_r = ir_target;
                        end
                    end
                    OP_RET: begin
                        if (ras_empty) begin
                            fault_d[FAULT_RAS] = 1'b1;
                            state_d            = S_HALT;
                        end else begin
                            ras_pop     = 1'b1;
                            jump_en_r   = 1'b1;
                            jump_addr_r = ras_top;
                        end
                    end
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        fault_d[FAULT_ILL] = 1'b1;
                        state_d            = S_HALT;
                    end
                endcase
            end

            S_MEMWAIT: begin
                dmem_req_r = 1'b1;
                dmem_we_r  = (opcode == OP_ST);
                if (dmem_ready) begin
                    pc_step_r = 1'b1;
                    reg_we_r  = (opcode == OP_LD);
                    state_d   = S_FETCH;
                end
            end

            S_HALT: halted_r = 1'b1;

            default: state_d = S_FETCH;
        endcase
    end

    // State, IR and sticky fault registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            fault_q <= fault_d;
        end
    end

    // Nothing escapes while reset is held, whatever state we were in
    assign imem_req  = imem_req_r & ~reset;
    assign pc_step   = pc_step_r  & ~reset;
    assign jump_en   = jump_en_r  & ~reset;
    assign jump_addr = reset ? '0 : jump_addr_r;
    assign alu_en    = alu_en_r   & ~reset;
    assign reg_we    = reg_we_r   & ~reset;
    assign dmem_req  = dmem_req_r & ~reset;
    assign dmem_we   = dmem_we_r  & ~reset;
    assign halted    = halted_r   & ~reset;
    assign ir_out    = ir_q;
    assign fault     = fault_q;

endmodule
